modulo_vector_driver: RTL and testbench

- Initiator for the Modulo unit's start/ready/done handshake.
- Walks a vector of signed Q16.16 coefficients from a source buffer and issues one Modulo request per coefficient, all against a common modulus p.
- Writes each reduced result to a destination buffer and signals completion of the vector.
- Sits between the key-generation sequencer (host side) and a single Modulo instance.

---
 rtl/modulo_vector_driver.sv | 219 +++++++++++++++++++++
 tb/tb_modulo_vector_driver.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_vector_driver.sv
// Vector initiator for a single Modulo unit. Walks vec_len signed Q16.16
// coefficients from a source buffer, reduces each one against a common
// modulus through the Modulo start/ready/done handshake, writes the results
// to a destination buffer at the same index and pulses vec_done at the end.
// At most one Modulo request is ever outstanding.
module modulo_vector_driver #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vec_start,
    input  logic [ADDR_WIDTH:0]   vec_len,
    input  logic [DATA_WIDTH-1:0] p_in,
    output logic                  busy,
    output logic                  vec_done,
    output logic [1:0]            err,
    output logic                  src_rd_en,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  dst_wr_en,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic                  mod_start,
    output logic [DATA_WIDTH-1:0] mod_m,
    output logic [DATA_WIDTH-1:0] mod_p,
    input  logic                  mod_ready,
    input  logic                  mod_done,
    input  logic [DATA_WIDTH-1:0] mod_result
);

    // Timeout counter only has to hold 0 .. TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]       TMO_ONE  = TW'(1);
    localparam logic [ADDR_WIDTH:0] IDX_ONE  = (ADDR_WIDTH + 1)'(1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_P_NONPOS = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_WRITE  = 3'd5,
        S_FINISH = 3'd6
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     idx_q, idx_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [DATA_WIDTH-1:0]   p_q, p_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [1:0]              err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    vec_done_q, vec_done_d;
    logic                    src_rd_en_q, src_rd_en_d;
    logic [ADDR_WIDTH-1:0]   src_addr_q, src_addr_d;
    logic                    dst_wr_en_q, dst_wr_en_d;
    logic [ADDR_WIDTH-1:0]   dst_addr_q, dst_addr_d;
    logic [DATA_WIDTH-1:0]   dst_data_q, dst_data_d;
    logic [DATA_WIDTH-1:0]   mod_m_q, mod_m_d;
    logic                    mod_start_s;
    logic                    p_nonpos_s;
    logic [ADDR_WIDTH:0]     idx_plus1_s;
    logic                    last_idx_s;

    // A zero or negative modulus is rejected before any buffer traffic.
    assign p_nonpos_s  = p_in[DATA_WIDTH-1] | (p_in == {DATA_WIDTH{1'b0}});
    assign idx_plus1_s = idx_q + IDX_ONE;
    assign last_idx_s  = (idx_q == (len_q - IDX_ONE));

    // Next-state and next-output decode; every register defaults to hold.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        p_d         = p_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        busy_d      = busy_q;
        vec_done_d  = 1'b0;
        src_rd_en_d = 1'b0;
        src_addr_d  = src_addr_q;
        dst_wr_en_d = 1'b0;
        dst_addr_d  = dst_addr_q;
        dst_data_d  = dst_data_q;
        mod_m_d     = mod_m_q;
        mod_start_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The cycle carrying vec_done is IDLE but must not accept.
                if (vec_start && !vec_done_q) begin
                    len_d  = vec_len;
                    p_d    = p_in;
                    idx_d  = {(ADDR_WIDTH + 1){1'b0}};
                    err_d  = ERR_OK;
                    busy_d = 1'b1;
                    if (p_nonpos_s) begin
                        err_d   = ERR_P_NONPOS;
                        state_d = S_FINISH;
                    end else if (vec_len == {(ADDR_WIDTH + 1){1'b0}}) begin
                        state_d = S_FINISH;
                    end else begin
                        src_rd_en_d = 1'b1;
                        src_addr_d  = {ADDR_WIDTH{1'b0}};
                        state_d     = S_FETCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // Source data is valid the cycle after the read strobe.
                mod_m_d = src_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (mod_ready) begin
                    mod_start_s = 1'b1;
                    tmo_d       = {TW{1'b0}};
                    state_d     = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                // A result arriving on the terminal count still wins.
                if (mod_done) begin
                    dst_wr_en_d = 1'b1;
                    dst_addr_d  = idx_q[ADDR_WIDTH-1:0];
                    dst_data_d  = mod_result;
                    state_d     = S_WRITE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_FINISH;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            S_WRITE: begin
                if (last_idx_s) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d       = idx_plus1_s;
                    src_rd_en_d = 1'b1;
                    src_addr_d  = idx_plus1_s[ADDR_WIDTH-1:0];
                    state_d     = S_FETCH;
                end
            end
            S_FINISH: begin
                vec_done_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any vector in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= {(ADDR_WIDTH + 1){1'b0}};
            len_q       <= {(ADDR_WIDTH + 1){1'b0}};
            p_q         <= {DATA_WIDTH{1'b0}};
            tmo_q       <= {TW{1'b0}};
            err_q       <= ERR_OK;
            busy_q      <= 1'b0;
            vec_done_q  <= 1'b0;
            src_rd_en_q <= 1'b0;
            src_addr_q  <= {ADDR_WIDTH{1'b0}};
            dst_wr_en_q <= 1'b0;
            dst_addr_q  <= {ADDR_WIDTH{1'b0}};
            dst_data_q  <= {DATA_WIDTH{1'b0}};
            mod_m_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            p_q         <= p_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            vec_done_q  <= vec_done_d;
            src_rd_en_q <= src_rd_en_d;
            src_addr_q  <= src_addr_d;
            dst_wr_en_q <= dst_wr_en_d;
            dst_addr_q  <= dst_addr_d;
            dst_data_q  <= dst_data_d;
            mod_m_q     <= mod_m_d;
        end
    end

    assign busy      = busy_q;
    assign vec_done  = vec_done_q;
    assign err       = err_q;
    assign src_rd_en = src_rd_en_q;
    assign src_addr  = src_addr_q;
    assign dst_wr_en = dst_wr_en_q;
    assign dst_addr  = dst_addr_q;
    assign dst_data  = dst_data_q;
    // mod_start must coincide with the cycle mod_ready is seen high.
    assign mod_start = mod_start_s;
    assign mod_m     = mod_m_q;
    assign mod_p     = p_q;

endmodule

// File: tb/tb_modulo_vector_driver.sv
// Scoreboarded bench for modulo_vector_driver: a behavioural Modulo unit and
// source buffer respond to the DUT, expected writes and completion codes are
// queued at stimulus time and popped by independent monitors.
module tb_modulo_vector_driver;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LW = AW + 1;
    localparam int TO = 16;

    logic          clk;
    logic          rst;
    logic          vec_start;
    logic [AW:0]   vec_len;
    logic [DW-1:0] p_in;
    logic          busy;
    logic          vec_done;
    logic [1:0]    err;
    logic          src_rd_en;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_data;
    logic          dst_wr_en;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] dst_data;
    logic          mod_start;
    logic [DW-1:0] mod_m;
    logic [DW-1:0] mod_p;
    logic          mod_ready;
    logic          mod_done;
    logic [DW-1:0] mod_result;

    modulo_vector_driver #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .vec_start(vec_start), .vec_len(vec_len), .p_in(p_in),
        .busy(busy), .vec_done(vec_done), .err(err),
        .src_rd_en(src_rd_en), .src_addr(src_addr), .src_data(src_data),
        .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_data(dst_data),
        .mod_start(mod_start), .mod_m(mod_m), .mod_p(mod_p),
        .mod_ready(mod_ready), .mod_done(mod_done), .mod_result(mod_result)
    );

    int checks = 0;
    int errors = 0;
    int n_rd = 0, n_start = 0, n_wr = 0, n_done = 0;
    int ready_delay = 0;
    bit never_done = 1'b0;
    int rst_epoch = 0;
    logic [DW-1:0] cur_p = '0;
    logic [DW-1:0] src_mem [0:(1<<AW)-1];
    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];
    logic [1:0]    exp_err_q  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Non-negative residue of signed m modulo positive p.
    function automatic logic [DW-1:0] ref_mod(input logic [DW-1:0] m, input logic [DW-1:0] p);
        longint r;
        r = longint'($signed(m)) % longint'($signed(p));
        if (r < 0) r = r + longint'($signed(p));
        return r[DW-1:0];
    endfunction

    // Source buffer: data for a strobed address appears the following cycle.
    initial begin : src_buffer
        logic          pend;
        logic [AW-1:0] a;
        src_data = '0;
        forever begin
            @(negedge clk);
            pend = src_rd_en;
            a    = src_addr;
            if (src_rd_en) n_rd++;
            @(posedge clk); #1;
            src_data = pend ? src_mem[a] : $urandom;
        end
    end

    // Behavioural Modulo unit: ready after a delay, result after a latency.
    initial begin : modulo_model
        logic [DW-1:0] m_cap, p_cap;
        int lat, ep;
        mod_ready = 1'b0; mod_done = 1'b0; mod_result = '0;
        forever begin
            @(posedge clk); #1;
            mod_done = 1'b0;
            mod_ready = 1'b0;
            for (int i = 0; i < ready_delay; i++) begin @(posedge clk); #1; end
            mod_ready = 1'b1;
            @(negedge clk);
            while (!mod_start) @(negedge clk);
            m_cap = mod_m; p_cap = mod_p; ep = rst_epoch;
            @(posedge clk); #1;
            mod_ready = 1'b0;
            lat = never_done ? TO + 4 : int'($urandom_range(0, 5));
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                if (rst_epoch == ep) check("mod_m_stable", 64'(mod_m), 64'(m_cap));
                @(posedge clk); #1;
            end
            if (!never_done) begin
                mod_done = 1'b1;
                mod_result = ref_mod(m_cap, p_cap);
            end
        end
    end

    // Request monitor: start only with ready, modulus is the latched one.
    initial forever begin
        @(negedge clk);
        if (mod_start) begin
            n_start++;
            check("start_needs_ready", 64'(mod_ready), 64'd1);
            check("mod_p", 64'(mod_p), 64'(cur_p));
        end
    end

    // Destination monitor: every write pops one expected (addr, data).
    initial forever begin
        @(negedge clk);
        if (dst_wr_en) begin
            n_wr++;
            if (exp_data_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: actual addr %0d data 0x%0h, required none", dst_addr, dst_data);
            end else begin
                check("dst_addr", 64'(dst_addr), 64'(exp_addr_q.pop_front()));
                check("dst_data", 64'(dst_data), 64'(exp_data_q.pop_front()));
            end
        end
    end

    // Completion monitor: each vec_done pops one expected error code.
    initial forever begin
        @(negedge clk);
        if (vec_done) begin
            n_done++;
            check("busy_with_done", 64'(busy), 64'd0);
            if (exp_err_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_vec_done: actual err %0d, required no completion", err);
            end else begin
                check("err", 64'(err), 64'(exp_err_q.pop_front()));
            end
        end
    end

    task automatic run_vector(input int len, input logic [DW-1:0] p, input int rdly,
                              input bit nd, input bit use_ref, input bit hold);
        logic [1:0] e;
        int exp_req, cyc;
        if ($signed(p) <= 0) e = 2'd1;
        else if (nd && len > 0) e = 2'd2;
        else e = 2'd0;
        exp_req = (e == 2'd1) ? 0 : ((e == 2'd2) ? 1 : len);
        if (e == 2'd0 && use_ref)
            for (int i = 0; i < len; i++) begin
                exp_addr_q.push_back(AW'(i));
                exp_data_q.push_back(ref_mod(src_mem[i], p));
            end
        exp_err_q.push_back(e);
        ready_delay = rdly; never_done = nd; cur_p = p;
        n_rd = 0; n_start = 0; n_wr = 0; n_done = 0;
        @(posedge clk); #1;
        vec_len = LW'(len); p_in = p; vec_start = 1'b1;
        @(posedge clk); #1;
        if (!hold) vec_start = 1'b0;
        vec_len = LW'($urandom); p_in = $urandom;
        @(negedge clk);
        cyc = 1;
        check("busy_after_accept", 64'(busy), 64'd1);
        while (!vec_done && cyc < 3000) begin @(negedge clk); cyc++; end
        if (!vec_done) begin
            checks++; errors++;
            $display("FAIL vec_done_wait: actual none after %0d cycles, required a pulse", cyc);
        end
        if (len == 0 || e == 2'd1) check("done_latency", 64'(cyc), 64'd2);
        @(posedge clk); #1;
        vec_start = 1'b0;
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'd0);
        repeat (10) @(negedge clk);
        check("src_reads", 64'(n_rd), 64'(exp_req));
        check("mod_starts", 64'(n_start), 64'(exp_req));
        check("writes", 64'(n_wr), 64'((e == 2'd0) ? len : 0));
        check("writes_pending", 64'(exp_data_q.size()), 64'd0);
        check("done_pulses", 64'(n_done), 64'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 64'({busy, vec_done, err, src_rd_en, dst_wr_en, mod_start, src_addr, dst_addr}), 64'd0);
        check({tag, "_data"}, 64'(dst_data | mod_m | mod_p), 64'd0);
    endtask

    initial begin : main
        logic [DW-1:0] p;
        int len, cyc;
        rst = 1'b0; vec_start = 1'b0; vec_len = '0; p_in = '0;
        for (int i = 0; i < (1 << AW); i++) src_mem[i] = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // -9.0 mod 4.0 = 3.0
        src_mem[0] = 32'hFFF70000;
        exp_addr_q.push_back(4'd0); exp_data_q.push_back(32'h00030000);
        run_vector(1, 32'h00040000, 0, 1'b0, 1'b0, 1'b0);

        // {9, -9, 20, 0} mod 4 = {1, 3, 0, 0}, plain and with slow ready
        for (int pass = 0; pass < 2; pass++) begin
            src_mem[0] = 32'h00090000; src_mem[1] = 32'hFFF70000;
            src_mem[2] = 32'h00140000; src_mem[3] = 32'h00000000;
            exp_addr_q.push_back(4'd0); exp_data_q.push_back(32'h00010000);
            exp_addr_q.push_back(4'd1); exp_data_q.push_back(32'h00030000);
            exp_addr_q.push_back(4'd2); exp_data_q.push_back(32'h00000000);
            exp_addr_q.push_back(4'd3); exp_data_q.push_back(32'h00000000);
            run_vector(4, 32'h00040000, (pass == 0) ? 0 : 7, 1'b0, 1'b0, 1'b0);
        end

        // Non-positive modulus, empty vector, Modulo timeout
        run_vector(3, 32'h00000000, 0, 1'b0, 1'b1, 1'b0);
        run_vector(3, 32'hFFFC0000, 0, 1'b0, 1'b1, 1'b0);
        run_vector(0, 32'h00040000, 0, 1'b0, 1'b1, 1'b0);
        run_vector(3, 32'h00040000, 0, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a vector
        for (int i = 0; i < 8; i++) src_mem[i] = $urandom;
        p = 32'h00070000;
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(AW'(i)); exp_data_q.push_back(ref_mod(src_mem[i], p));
        end
        exp_err_q.push_back(2'd0);
        ready_delay = 0; never_done = 1'b0; cur_p = p; n_wr = 0;
        @(posedge clk); #1;
        vec_len = LW'(8); p_in = p; vec_start = 1'b1;
        @(posedge clk); #1;
        vec_start = 1'b0;
        cyc = 0;
        while (n_wr < 2 && cyc < 500) begin @(negedge clk); cyc++; end
        check("abort_progress", 64'(n_wr >= 2), 64'd1);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        rst_epoch++;
        check_outputs_zero("abort");
        exp_addr_q.delete(); exp_data_q.delete(); exp_err_q.delete();
        n_wr = 0; n_done = 0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_write", 64'(n_wr), 64'd0);
        check("abort_no_done", 64'(n_done), 64'd0);
        for (int i = 0; i < 5; i++) src_mem[i] = $urandom;
        run_vector(5, 32'h00050000, 1, 1'b0, 1'b1, 1'b0);

        // Random vectors, including full length and vec_start held high
        for (int t = 0; t < 8; t++) begin
            len = (t == 0) ? (1 << AW) : int'($urandom_range(1, 1 << AW));
            for (int i = 0; i < (1 << AW); i++) src_mem[i] = $urandom;
            if (t == 7) p = 32'h80000000 | $urandom;
            else if (t[0]) p = {1'b0, 31'($urandom)} | 32'd1;
            else p = 32'($urandom_range(1, 1000)) << 16;
            run_vector(len, p, int'($urandom_range(0, 3)), 1'b0, 1'b1, (t == 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
